// File: rtl/rf_sb.sv
// Register file with a per-register busy scoreboard: write-through read ports,
// destination reservation on issue, release on write-back, and a running busy count.
module rf_sb #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRD = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              WrEn,
    input  logic [AW-1:0]     Rw,
    input  logic [DW-1:0]     busW,
    input  logic [NRD*AW-1:0] Ra,
    output logic [NRD*DW-1:0] busR,
    output logic [NRD-1:0]    RdBusy,
    input  logic              IssueEn,
    input  logic [AW-1:0]     IssueRd,
    input  logic              Flush,
    output logic [AW:0]       BusyCnt
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0]    regs [DEPTH];
    logic [DEPTH-1:0] busy;

    logic             wr_ok;
    logic             iss_ok;
    logic             set_ev;
    logic             clr_ev;
    logic [AW:0]      cnt_next;

    assign wr_ok  = WrEn && (Rw != '0);
    assign iss_ok = IssueEn && (IssueRd != '0);

    // Count only real transitions; a same-address issue keeps the bit set, so no release.
    assign set_ev = iss_ok && !busy[IssueRd];
    assign clr_ev = wr_ok && busy[Rw] && !(iss_ok && (IssueRd == Rw));

    always_comb begin
        cnt_next = BusyCnt;
        if (Flush) begin
            cnt_next = '0;
        end else begin
            cnt_next = BusyCnt + {{AW{1'b0}}, set_ev} - {{AW{1'b0}}, clr_ev};
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[Rw] <= busW;
        end
    end

    // Issue is applied after the write-back release so it wins on a collision.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            busy    <= '0;
            BusyCnt <= '0;
        end else begin
            BusyCnt <= cnt_next;
            if (Flush) begin
                busy <= '0;
            end else begin
                if (wr_ok) begin
                    busy[Rw] <= 1'b0;
                end
                if (iss_ok) begin
                    busy[IssueRd] <= 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          hit;

        assign ra  = Ra[k*AW +: AW];
        assign hit = WrEn && (Rw == ra);

        assign busR[k*DW +: DW] = (ra == '0) ? '0 :
                                  hit        ? busW : regs[ra];
        assign RdBusy[k]        = (ra != '0) && busy[ra] && !hit;
    end

endmodule

// File: tb/tb_rf_sb.sv
// Bench for rf_sb: directed vector table, randomized run against an array-based
// scoreboard model, and hand-written asynchronous reset sequences.
module tb_rf_sb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NRD   = 4;
    localparam int DEPTH = 2 ** AW;

    logic              Clk;
    logic              Rst_n;
    logic              WrEn;
    logic [AW-1:0]     Rw;
    logic [DW-1:0]     busW;
    logic [NRD*AW-1:0] Ra;
    logic [NRD*DW-1:0] busR;
    logic [NRD-1:0]    RdBusy;
    logic              IssueEn;
    logic [AW-1:0]     IssueRd;
    logic              Flush;
    logic [AW:0]       BusyCnt;

    rf_sb #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .WrEn    (WrEn),
        .Rw      (Rw),
        .busW    (busW),
        .Ra      (Ra),
        .busR    (busR),
        .RdBusy  (RdBusy),
        .IssueEn (IssueEn),
        .IssueRd (IssueRd),
        .Flush   (Flush),
        .BusyCnt (BusyCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: plain arrays of register values and reservation flags.
    logic [DW-1:0] m_r [DEPTH];
    bit            m_b [DEPTH];

    typedef struct {
        logic          wr;
        logic [AW-1:0] rw;
        logic [DW-1:0] wd;
        logic          iss;
        logic [AW-1:0] ird;
        logic          fl;
        logic [AW-1:0] ra0;
        logic [DW-1:0] e_busr;
        logic          e_busy;
        logic [AW:0]   e_cnt;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_r[i] = '0;
            m_b[i] = 1'b0;
        end
    endtask

    function automatic logic [DW-1:0] exp_busr(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (WrEn && Rw == a) return busW;
        return m_r[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        return m_b[a] && !(WrEn && Rw == a);
    endfunction

    function automatic int model_cnt();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m_b[i]);
        return c;
    endfunction

    task automatic model_update();
        if (WrEn && Rw != 0) m_r[Rw] = busW;
        if (Flush) begin
            for (int i = 0; i < DEPTH; i++) m_b[i] = 1'b0;
        end else begin
            if (WrEn && Rw != 0) m_b[Rw] = 1'b0;
            if (IssueEn && IssueRd != 0) m_b[IssueRd] = 1'b1;
        end
    endtask

    task automatic check_comb_model();
        for (int k = 0; k < NRD; k++) begin
            chk($sformatf("busR[%0d]", k), busR[k*DW +: DW], exp_busr(Ra[k*AW +: AW]));
            chk($sformatf("RdBusy[%0d]", k), {31'd0, RdBusy[k]}, {31'd0, exp_busy(Ra[k*AW +: AW])});
        end
    endtask

    // Inputs already driven at the falling edge; check, clock, update model, check count.
    task automatic do_cycle();
        #1;
        check_comb_model();
        @(posedge Clk);
        model_update();
        #1;
        chk("BusyCnt", {26'd0, BusyCnt}, model_cnt());
        @(negedge Clk);
    endtask

    task automatic idle_inputs();
        WrEn = 0; Rw = '0; busW = '0; IssueEn = 0; IssueRd = '0; Flush = 0;
    endtask

    logic [AW-1:0] r_tmp;

    initial begin
        // wr rw wd iss ird fl ra0 | busr0 busy0 cnt_after
        tbl[0]  = '{1, 10, 32'd7,          0, 0,  0, 10, 32'd7,    0, 0};
        tbl[1]  = '{0, 0,  32'd0,          0, 0,  0, 10, 32'd7,    0, 0};
        tbl[2]  = '{1, 0,  32'hFFFF_FFFF,  1, 0,  0, 0,  32'd0,    0, 0};
        tbl[3]  = '{0, 0,  32'd0,          0, 0,  0, 0,  32'd0,    0, 0};
        tbl[4]  = '{0, 0,  32'd0,          1, 11, 0, 11, 32'd0,    0, 1};
        tbl[5]  = '{0, 0,  32'd0,          1, 20, 0, 11, 32'd0,    1, 2};
        tbl[6]  = '{1, 11, 32'd15,         0, 0,  0, 11, 32'd15,   0, 1};
        tbl[7]  = '{0, 0,  32'd0,          0, 0,  0, 11, 32'd15,   0, 1};
        tbl[8]  = '{0, 0,  32'd0,          1, 5,  0, 5,  32'd0,    0, 2};
        tbl[9]  = '{1, 5,  32'h55,         1, 5,  0, 5,  32'h55,   0, 2};
        tbl[10] = '{0, 0,  32'd0,          0, 0,  0, 5,  32'h55,   1, 2};
        tbl[11] = '{1, 20, 32'd3,          1, 9,  0, 20, 32'd3,    0, 2};
        tbl[12] = '{0, 0,  32'd0,          1, 9,  0, 9,  32'd0,    1, 2};
        tbl[13] = '{1, 12, 32'd1,          0, 0,  0, 9,  32'd0,    1, 2};
        tbl[14] = '{0, 0,  32'd0,          1, 30, 0, 30, 32'd0,    0, 3};
        tbl[15] = '{1, 7,  32'h77,         1, 7,  1, 30, 32'd0,    1, 0};
        tbl[16] = '{0, 0,  32'd0,          0, 0,  0, 7,  32'h77,   0, 0};
        tbl[17] = '{0, 0,  32'd0,          0, 0,  0, 30, 32'd0,    0, 0};

        idle_inputs();
        Ra    = '0;
        Rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge Clk);
        #1;
        chk("reset BusyCnt", {26'd0, BusyCnt}, 32'd0);
        chk("reset RdBusy", {28'd0, RdBusy}, 32'd0);
        chk("reset busR", busR[DW-1:0], 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Directed table; ports 1..3 hold fixed addresses and are checked by the model.
        for (int i = 0; i < 18; i++) begin
            WrEn = tbl[i].wr; Rw = tbl[i].rw; busW = tbl[i].wd;
            IssueEn = tbl[i].iss; IssueRd = tbl[i].ird; Flush = tbl[i].fl;
            Ra = {5'd9, 5'd5, 5'd30, tbl[i].ra0};
            #1;
            chk($sformatf("vec%0d busR0", i), busR[DW-1:0], tbl[i].e_busr);
            chk($sformatf("vec%0d RdBusy0", i), {31'd0, RdBusy[0]}, {31'd0, tbl[i].e_busy});
            check_comb_model();
            @(posedge Clk);
            model_update();
            #1;
            chk($sformatf("vec%0d BusyCnt", i), {26'd0, BusyCnt}, {26'd0, tbl[i].e_cnt});
            @(negedge Clk);
        end
        chk("flush RdBusy all", {28'd0, RdBusy}, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            WrEn    = ($urandom_range(0, 1) == 1);
            Rw      = AW'($urandom_range(0, DEPTH - 1));
            busW    = $urandom;
            IssueEn = ($urandom_range(0, 9) < 4);
            IssueRd = ($urandom_range(0, 4) == 0) ? Rw : AW'($urandom_range(0, DEPTH - 1));
            Flush   = ($urandom_range(0, 29) == 0);
            for (int k = 0; k < NRD; k++) begin
                r_tmp = ($urandom_range(0, 3) == 0) ? Rw : AW'($urandom_range(0, DEPTH - 1));
                Ra[k*AW +: AW] = r_tmp;
            end
            do_cycle();
        end

        // Mid-operation asynchronous reset.
        idle_inputs();
        Flush = 1; Ra = '0;
        do_cycle();
        Flush = 0; IssueEn = 1; IssueRd = 5'd1;
        do_cycle();
        IssueRd = 5'd2;
        do_cycle();
        IssueRd = 5'd3; WrEn = 1; Rw = 5'd20; busW = 32'd128;
        do_cycle();
        chk("pre-reset BusyCnt", {26'd0, BusyCnt}, 32'd3);
        idle_inputs();
        Ra = {5'd0, 5'd0, 5'd2, 5'd20};
        #1;
        chk("pre-reset busR20", busR[DW-1:0], 32'd128);
        #1;
        Rst_n = 1'b0;
        #1;
        chk("async BusyCnt", {26'd0, BusyCnt}, 32'd0);
        chk("async busR20", busR[DW-1:0], 32'd0);
        chk("async RdBusy", {28'd0, RdBusy}, 32'd0);
        model_clear();

        // Controls are ignored in reset, but the write-through path stays combinational.
        WrEn = 1; Rw = 5'd20; busW = 32'd9; IssueEn = 1; IssueRd = 5'd6; Flush = 0;
        #1;
        chk("reset bypass busR", busR[DW-1:0], 32'd9);
        chk("reset bypass RdBusy", {31'd0, RdBusy[0]}, 32'd0);
        @(posedge Clk);
        #1;
        chk("reset hold BusyCnt", {26'd0, BusyCnt}, 32'd0);
        WrEn = 0;
        #1;
        chk("reset hold busR20", busR[DW-1:0], 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        idle_inputs();
        IssueEn = 1; IssueRd = 5'd4; Ra = {5'd0, 5'd0, 5'd0, 5'd4};
        do_cycle();
        chk("post-reset BusyCnt", {26'd0, BusyCnt}, 32'd1);
        idle_inputs();
        #1;
        chk("post-reset RdBusy4", {31'd0, RdBusy[0]}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rf_sb.md
RF_SB -- requirements
Module: rf_sb

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits.
REQ-002 SHALL have parameter AW, default 5, address width; depth = 2**AW registers.
REQ-003 SHALL have parameter NRD, default 4, number of independent read ports.
REQ-004 SHALL have port Clk  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port WrEn  input  1  write-back enable.
REQ-007 SHALL have port Rw  input  AW  write-back address.
REQ-008 SHALL have port busW  input  DW  write-back data.
REQ-009 SHALL have port Ra  input  NRD*AW  read addresses, port k at bits [k*AW +: AW].
REQ-010 SHALL have port busR  output  NRD*DW  read data, port k at bits [k*DW +: DW].
REQ-011 SHALL have port RdBusy  output  NRD  per-port pending-write flag.
REQ-012 SHALL have port IssueEn  input  1  reserve a destination register.
REQ-013 SHALL have port IssueRd  input  AW  destination to reserve.
REQ-014 SHALL have port Flush  input  1  synchronous clear of all reservations.
REQ-015 SHALL have port BusyCnt  output  AW+1  number of currently reserved registers.

Function
REQ-016 SHALL hold 2**AW data registers R[i] and 2**AW busy bits B[i].
REQ-017 SHALL, on posedge with WrEn=1 and Rw!=0, load R[Rw] <= busW; writes to address 0 SHALL be discarded.
REQ-018 SHALL drive busR port k = 0 when Ra_k=0; = busW when WrEn=1 and Rw=Ra_k (same-cycle write-through bypass); else R[Ra_k]; purely combinational.
REQ-019 SHALL, on posedge with WrEn=1 and Rw!=0, clear B[Rw].
REQ-020 SHALL, on posedge with IssueEn=1 and IssueRd!=0, set B[IssueRd]; issue to address 0 SHALL be ignored.
REQ-021 SHALL, when IssueEn and WrEn target the same nonzero address in one cycle, leave B set (issue wins; the write still updates R).
REQ-022 SHALL, on posedge with Flush=1, clear every B[i], overriding IssueEn and WrEn effects on B that cycle; R writes SHALL still occur.
REQ-023 SHALL drive RdBusy[k] = B[Ra_k] & ~(WrEn & Rw==Ra_k); RdBusy[k]=0 when Ra_k=0; combinational.
REQ-024 SHALL maintain BusyCnt as a registered count equal to the number of set B bits after each edge: +1 for a clear-to-set transition, -1 for a set-to-clear transition, net 0 when both occur on different addresses in one cycle, 0 after Flush.
REQ-025 SHALL NOT change BusyCnt when IssueEn targets an already-busy register or WrEn targets a non-busy one.
REQ-026 SHALL keep B[0]=0 and R[0]=0 at all times; BusyCnt SHALL never exceed 2**AW-1.

Reset
REQ-027 SHALL, while Rst_n=0, asynchronously clear all R[i] to 0, all B[i] to 0, and BusyCnt to 0.
REQ-028 SHALL ignore WrEn, IssueEn and Flush while Rst_n=0; the first update occurs at the first posedge after Rst_n rises.
REQ-029 SHALL drive busR=0 and RdBusy=0 during reset unless the bypass of REQ-018/REQ-023 applies.

Verification
REQ-030 Bypass: WrEn=1, Rw=10, busW=7, Ra_0=10 in the same cycle -> busR_0=7 before the edge; after the edge with WrEn=0 -> busR_0=7.
REQ-031 Zero register: WrEn=1, Rw=0, busW=0xFFFFFFFF; IssueEn=1, IssueRd=0 -> busR for Ra=0 reads 0, RdBusy=0, BusyCnt unchanged.
REQ-032 Scoreboard: issue 11, then issue 20 -> BusyCnt=2, RdBusy=1 for Ra=11; write back Rw=11, busW=15 -> RdBusy=0 in the write cycle, BusyCnt=1 after the edge, busR=15.
REQ-033 Collision: B[5]=1, IssueEn=1 and IssueRd=5 with WrEn=1 and Rw=5 in one cycle -> B[5] stays 1, R[5]=busW, BusyCnt unchanged.
REQ-034 Flush: 3 registers busy; Flush=1 with IssueEn=1 and IssueRd=7 -> BusyCnt=0, all RdBusy=0 next cycle.
REQ-035 Mid-operation reset: BusyCnt=3 and R[20]=128; assert Rst_n=0 between edges -> BusyCnt=0 and busR for Ra=20 reads 0 immediately, without waiting for an edge.
